sha1_engine: RTL and testbench

//  Parametrised multi-block SHA-1 compression engine with streaming word input.

---
 rtl/sha1_pkg.sv | 53 +++++
 rtl/sha1_engine_if.sv | 11 +
 rtl/sha1_sched.sv | 47 ++++
 rtl/sha1_engine.sv | 112 +++++++++++
 tb/tb_sha1_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_pkg.sv
// SHA-1 shared definitions: IV, round constants, FSM states and one-round function.
// Pure combinational helpers; no state lives here.
package sha1_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FOLD} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } abcde_t;

    localparam logic [31:0] H0_IV = 32'h67452301;
    localparam logic [31:0] H1_IV = 32'hefcdab89;
    localparam logic [31:0] H2_IV = 32'h98badcfe;
    localparam logic [31:0] H3_IV = 32'h10325476;
    localparam logic [31:0] H4_IV = 32'hc3d2e1f0;
    localparam abcde_t SHA1_IV = {H0_IV, H1_IV, H2_IV, H3_IV, H4_IV};

    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;

    function automatic abcde_t sha1_round(input logic [6:0] t, input abcde_t s,
                                          input logic [31:0] w);
        logic [31:0] f;
        logic [31:0] k;
        abcde_t r;
        if (t < 7'd20) begin
            f = (s.b & s.c) | (~s.b & s.d);
            k = K0;
        end else if (t < 7'd40) begin
            f = s.b ^ s.c ^ s.d;
            k = K1;
        end else if (t < 7'd60) begin
            f = (s.b & s.c) | (s.b & s.d) | (s.c & s.d);
            k = K2;
        end else begin
            f = s.b ^ s.c ^ s.d;
            k = K3;
        end
        r.a = {s.a[26:0], s.a[31:27]} + f + s.e + k + w;
        r.b = s.a;
        r.c = {s.b[1:0], s.b[31:2]};
        r.d = s.c;
        r.e = s.d;
        return r;
    endfunction

endpackage

// File: rtl/sha1_engine_if.sv
// Streaming message-word port: one 32-bit word per valid/ready beat, last flag with word 0.
// Ready is driven by the engine; the source holds data while valid and not ready.
interface sha1_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/sha1_sched.sv
// 16-entry circular message schedule; written word by word during load, expands UNROLL words per cycle.
// Zero latency on reads; writes land on the next clock edge; no backpressure of its own.
module sha1_sched
    import sha1_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [3:0]               wr_idx,
    input  logic [31:0]              wr_dat,
    input  logic                     adv,
    input  logic [6:0]               t,
    output logic [UNROLL-1:0][31:0]  w
);

    logic [31:0] mem [16];

    // Slot t[3:0] still holds w[t-16] until this cycle's write, so it doubles as the t-16 tap.
    for (genvar j = 0; j < UNROLL; j++) begin : g_w
        logic [6:0]  tj;
        logic [31:0] m3;
        logic [31:0] x;
        assign tj = t + 7'(j);
        if (j >= 3) begin : g_chain
            assign m3 = w[j-3];
        end else begin : g_mem
            assign m3 = mem[tj[3:0] - 4'd3];
        end
        assign x    = m3 ^ mem[tj[3:0] - 4'd8] ^ mem[tj[3:0] - 4'd14] ^ mem[tj[3:0]];
        assign w[j] = (tj < 7'd16) ? mem[tj[3:0]] : {x[30:0], x[31]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end else if (adv) begin
            for (int j = 0; j < UNROLL; j++) begin
                if (t + 7'(j) >= 7'd16) mem[4'(t + 7'(j))] <= w[j];
            end
        end
    end

endmodule

// File: rtl/sha1_engine.sv
// Multi-block SHA-1 compression: 16-word load, 80/UNROLL round cycles, one fold cycle.
// in_ready high only in IDLE/LOAD; digest_valid pulses 80/UNROLL+1 cycles after word 15.
module sha1_engine
    import sha1_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init,
    input  logic           abort,
    sha1_engine_if.slave   bus,
    output logic           busy,
    output logic [159:0]   digest,
    output logic           digest_valid
);

    if (20 % UNROLL != 0) begin : g_bad_unroll
        $error("sha1_engine: UNROLL must divide 20");
    end

    state_t      state;
    logic [3:0]  cnt;
    logic [6:0]  t;
    abcde_t      h;
    abcde_t      st;
    logic        last_blk;
    logic        accept;

    logic [UNROLL-1:0][31:0] w;
    abcde_t chain [UNROLL+1];

    assign bus.in_ready = (state == IDLE) || (state == LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != IDLE);
    assign digest       = h;

    sha1_sched #(.UNROLL(UNROLL)) u_sched (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept && !abort),
        .wr_idx (cnt),
        .wr_dat (bus.in_data),
        .adv    (state == ROUND),
        .t      (t),
        .w      (w)
    );

    assign chain[0] = st;
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        assign chain[j+1] = sha1_round(t + 7'(j), chain[j], w[j]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            t            <= 7'd0;
            h            <= SHA1_IV;
            st           <= '0;
            last_blk     <= 1'b0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                cnt      <= 4'd0;
                t        <= 7'd0;
                h        <= SHA1_IV;
                last_blk <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (init) h <= SHA1_IV;
                        // init on the same beat as word 0 restarts from IV rather than chaining
                        if (accept) begin
                            st       <= init ? SHA1_IV : h;
                            last_blk <= bus.in_last;
                            cnt      <= 4'd1;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            cnt <= cnt + 4'd1;
                            if (cnt == 4'd15) begin
                                state <= ROUND;
                                t     <= 7'd0;
                            end
                        end
                    end
                    ROUND: begin
                        st <= chain[UNROLL];
                        t  <= t + 7'(UNROLL);
                        if (t + 7'(UNROLL) == 7'd80) state <= FOLD;
                    end
                    FOLD: begin
                        h.a          <= h.a + st.a;
                        h.b          <= h.b + st.b;
                        h.c          <= h.c + st.c;
                        h.d          <= h.d + st.d;
                        h.e          <= h.e + st.e;
                        digest_valid <= last_blk;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha1_engine.sv
// Directed-vector bench: four engines (UNROLL 1,2,4,5) run the same sequences concurrently.
// Checks digests, latency, handshake, abort and async reset against hand-computed values.
module tb_sha1_engine;

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    localparam logic [511:0] B_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {{15{32'h0}}, 32'h000001c0};

    typedef struct {
        string          name;
        int             nblk;
        logic [1023:0]  blocks;
        logic [159:0]   expd;
    } vec_t;

    vec_t vecs [3];

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [3:0]    rst;
    logic [3:0]    init;
    logic [3:0]    abort;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [31:0]   in_data [4];
    logic [3:0]    in_ready;
    logic [3:0]    busy;
    logic [3:0]    dv;
    logic [159:0]  digest [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : gu
        localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
        sha1_engine_if bus ();
        logic [159:0] dg;
        logic         bs;
        logic         dvv;
        assign bus.in_valid = in_valid[g];
        assign bus.in_data  = in_data[g];
        assign bus.in_last  = in_last[g];
        assign in_ready[g]  = bus.in_ready;
        assign busy[g]      = bs;
        assign dv[g]        = dvv;
        assign digest[g]    = dg;

        sha1_engine #(.UNROLL(U)) dut (
            .clk          (clk),
            .rst          (rst[g]),
            .init         (init[g]),
            .abort        (abort[g]),
            .bus          (bus),
            .busy         (bs),
            .digest       (dg),
            .digest_valid (dvv)
        );
    end

    function automatic int uval(input int u);
        return (u == 0) ? 1 : (u == 1) ? 2 : (u == 2) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input int u, input logic [159:0] got,
                       input logic [159:0] expd);
        n_checks++;
        if (got !== expd) begin
            n_fail++;
            $display("FAIL %s (UNROLL=%0d): got %h, expected %h", name, uval(u), got, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init(input int u);
        init[u] = 1'b1;
        tick();
        init[u] = 1'b0;
    endtask

    // Word 0 and word 15 acceptance cycles are reported for latency checks.
    task automatic send_block(input int u, input logic [511:0] blk, input logic last,
                              input logic gaps, input logic init_w0,
                              output int a0, output int a15);
        int   i = 0;
        int   budget = 0;
        logic rdy;
        a0  = 0;
        a15 = 0;
        while (i < 16 && budget < 300) begin
            in_valid[u] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data[u]  = blk[511 - 32*i -: 32];
            in_last[u]  = last;
            init[u]     = init_w0 && (i == 0);
            rdy         = in_ready[u];
            tick();
            if (in_valid[u] && rdy) begin
                if (i == 0)  a0  = cyc;
                if (i == 15) a15 = cyc;
                i++;
            end
            budget++;
        end
        in_valid[u] = 1'b0;
        init[u]     = 1'b0;
        if (i < 16) chk("send_timeout", u, 160'(i), 160'd16);
    endtask

    task automatic run_msg(input int u, input vec_t v, input logic gaps, input logic init_w0);
        int   a0, a15, first_a0, c1, pulses, k;
        logic ok;
        first_a0 = 0;
        if (!init_w0) begin
            pulse_init(u);
            chk({v.name, "_init_iv"}, u, digest[u], IV);
        end
        for (int b = 0; b < v.nblk; b++) begin
            send_block(u, (b == 0) ? v.blocks[1023:512] : v.blocks[511:0],
                       b == v.nblk - 1, gaps, init_w0 && (b == 0), a0, a15);
            if (b == 0) first_a0 = a0;
            chk({v.name, "_ready_in_round"}, u, 160'(in_ready[u]), 160'd0);
            if (b < v.nblk - 1) begin
                pulses = 0;
                k = 0;
                while (busy[u] && k < 200) begin
                    tick();
                    if (dv[u]) pulses++;
                    k++;
                end
                chk({v.name, "_no_mid_pulse"}, u, 160'(pulses), 160'd0);
            end else begin
                ok = 1'b0;
                c1 = 0;
                for (int n = 0; n < 200 && !ok; n++) begin
                    tick();
                    if (dv[u]) begin
                        ok = 1'b1;
                        c1 = cyc;
                    end
                end
                chk({v.name, "_dv_seen"}, u, 160'(ok), 160'd1);
                chk({v.name, "_digest"}, u, digest[u], v.expd);
                chk({v.name, "_lat_w15"}, u, 160'(c1 - a15), 160'(80 / uval(u) + 1));
                if (v.nblk == 1 && !gaps)
                    chk({v.name, "_lat_w0"}, u, 160'(c1 - first_a0), 160'(16 + 80 / uval(u)));
                tick();
                chk({v.name, "_single_pulse"}, u, 160'(dv[u]), 160'd0);
                chk({v.name, "_idle_after"}, u, 160'(busy[u]), 160'd0);
            end
        end
    endtask

    task automatic run_unit(input int u);
        int a0, a15;
        vec_t abc;
        abc = vecs[0];

        chk("reset_digest", u, digest[u], IV);
        chk("reset_busy", u, 160'(busy[u]), 160'd0);
        chk("reset_dv", u, 160'(dv[u]), 160'd0);
        chk("reset_ready", u, 160'(in_ready[u]), 160'd1);

        for (int i = 0; i < 3; i++) run_msg(u, vecs[i], 1'b0, 1'b0);

        run_msg(u, abc, 1'b1, 1'b0);
        // H holds the "abc" digest here; init with word 0 must still restart from IV.
        run_msg(u, abc, 1'b0, 1'b1);

        // Abort partway through the rounds, with init and valid also raised.
        pulse_init(u);
        send_block(u, B_ABC, 1'b1, 1'b0, 1'b0, a0, a15);
        repeat (30 / uval(u)) tick();
        chk("abort_mid_round_busy", u, 160'(busy[u]), 160'd1);
        abort[u]    = 1'b1;
        init[u]     = 1'b1;
        in_valid[u] = 1'b1;
        tick();
        abort[u]    = 1'b0;
        init[u]     = 1'b0;
        in_valid[u] = 1'b0;
        chk("abort_busy", u, 160'(busy[u]), 160'd0);
        chk("abort_digest", u, digest[u], IV);
        chk("abort_dv", u, 160'(dv[u]), 160'd0);
        tick();
        chk("abort_no_late_dv", u, 160'(dv[u]), 160'd0);
        run_msg(u, abc, 1'b0, 1'b1);

        // Reset mid-LOAD while H holds a non-IV digest.
        for (int i = 0; i < 5; i++) begin
            in_valid[u] = 1'b1;
            in_data[u]  = B_ABC[511 - 32*i -: 32];
            in_last[u]  = 1'b1;
            tick();
        end
        in_valid[u] = 1'b0;
        chk("rst_pre_busy", u, 160'(busy[u]), 160'd1);
        rst[u] = 1'b1;
        #1;
        chk("rst_busy", u, 160'(busy[u]), 160'd0);
        chk("rst_digest", u, digest[u], IV);
        chk("rst_dv", u, 160'(dv[u]), 160'd0);
        tick();
        rst[u] = 1'b0;
        tick();
        run_msg(u, abc, 1'b0, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name: "abc",   nblk: 1, blocks: {B_ABC, 512'h0},   expd: D_ABC};
        vecs[1] = '{name: "empty", nblk: 1, blocks: {B_EMPTY, 512'h0}, expd: D_EMPTY};
        vecs[2] = '{name: "two",   nblk: 2, blocks: {B_TWO1, B_TWO2},  expd: D_TWO};
        rst      = 4'hf;
        init     = 4'h0;
        abort    = 4'h0;
        in_valid = 4'h0;
        in_last  = 4'h0;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h0;
        #12;
        rst = 4'h0;
        tick();
        fork
            run_unit(0);
            run_unit(1);
            run_unit(2);
            run_unit(3);
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
